// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-subtractor cell and a registered borrow. The operation is
// started with a start/busy/done handshake, and results are held until the next
// completion.
module serial_full_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Reject illegal widths at elaboration
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_full_subtractor: WIDTH must be >= 2");
  end

  logic [1:0]       state_q, state_d;
  // Minuend register doubles as the result register: each difference bit
  // enters at the MSB as the consumed minuend bit leaves at the LSB.
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             ovf_q, ovf_d;

  logic ai, bi, bin, d_bit, bout;

  // Full-subtractor cell on the current LSBs and the stored borrow
  always_comb begin
    ai    = a_sr_q[0];
    bi    = b_sr_q[0];
    bin   = brw_q;
    d_bit = ai ^ bi ^ bin;
    bout  = (~ai & bi) | (~(ai ^ bi) & bin);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    cnt_d        = cnt_q;
    brw_d        = brw_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          brw_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        a_sr_d = {d_bit, a_sr_q[WIDTH-1:1]};
        b_sr_d = b_sr_q >> 1;
        brw_d  = bout;
        if (cnt_q == CNT_LAST) begin
          diff_d       = {d_bit, a_sr_q[WIDTH-1:1]};
          borrow_out_d = bout;
          ovf_d        = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          busy_d       = 1'b0;
          done_d       = 1'b1;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      cnt_q        <= '0;
      brw_q        <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      cnt_q        <= cnt_d;
      brw_q        <= brw_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed and random bench for serial_full_subtractor (WIDTH=8).
module tb_serial_full_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       ovf;

  int n_checks;
  int n_fail;

  serial_full_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run one operation from IDLE; lat is edges from capture to done (-1 on timeout)
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] d, output logic bo, output logic ov,
                       output int lat);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'h00; b = 8'h00;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    d = diff; bo = borrow_out; ov = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, diff, borrow_out, ovf} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0",
               busy, done, diff, borrow_out, ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_capture: busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'h00) begin
          n_fail++;
          $display("FAIL basic_shift%0d: busy=%b done=%b diff=%h, want 1 0 00", i, busy, done, diff);
        end
      end
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1 || diff !== 8'h1E || borrow_out !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: busy=%b done=%b diff=%h bo=%b ovf=%b, want 0 1 1e 0 0",
               busy, done, diff, borrow_out, ovf);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h1E) begin
      n_fail++;
      $display("FAIL basic_after: done=%b busy=%b diff=%h, want 0 0 1e", done, busy, diff);
    end
  endtask

  task automatic test_borrow_ovf();
    logic [7:0] d; logic bo, ov; int lat;
    do_op(8'h00, 8'h01, d, bo, ov, lat);
    n_checks++;
    if (lat !== 8 || d !== 8'hFF || bo !== 1'b1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL borrow_00_01: lat=%0d diff=%h bo=%b ovf=%b, want 8 ff 1 0", lat, d, bo, ov);
    end
    @(posedge clk); #1;
    do_op(8'h80, 8'h01, d, bo, ov, lat);
    n_checks++;
    if (lat !== 8 || d !== 8'h7F || bo !== 1'b0 || ov !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_80_01: lat=%0d diff=%h bo=%b ovf=%b, want 8 7f 0 1", lat, d, bo, ov);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) begin
        a = 8'hFF; b = 8'hFF; start = 1'b1;
      end
      @(posedge clk); #1;
      if (i == 4) start = 1'b0;
      if (done) dones++;
    end
    n_checks++;
    if (done !== 1'b1 || diff !== 8'h0F || borrow_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_shift: done=%b diff=%h bo=%b, want 1 0f 0", done, diff, borrow_out);
    end
    // Request while in DONE must be dropped
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_done_busy%0d: busy=%b, want 0", i, busy);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (dones !== 1 || diff !== 8'h0F) begin
      n_fail++;
      $display("FAIL ignore_count: done pulses=%0d diff=%h, want 1 0f", dones, diff);
    end
  endtask

  task automatic test_back_to_back();
    a = 8'h03; b = 8'h05; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== ((cyc % 10) == 9)) begin
        n_fail++;
        $display("FAIL b2b_done_c%0d: done=%b, want %b", cyc, done, (cyc % 10) == 9);
      end
      if ((cyc % 10) == 9) begin
        n_checks++;
        if (diff !== 8'hFE || borrow_out !== 1'b1 || ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_result_c%0d: diff=%h bo=%b ovf=%b, want fe 1 0", cyc, diff, borrow_out, ovf);
        end
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic bo, ov; int lat;
    do_op(8'hFF, 8'h00, d, bo, ov, lat);   // leave nonzero held results
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, diff, borrow_out, ovf} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0",
               busy, done, diff, borrow_out, ovf);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done%0d: done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
    do_op(8'h09, 8'h09, d, bo, ov, lat);
    n_checks++;
    if (lat !== 8 || d !== 8'h00 || bo !== 1'b0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_recover: lat=%0d diff=%h bo=%b ovf=%b, want 8 00 0 0", lat, d, bo, ov);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] av, bv, d, ed; logic bo, ov, eb, eo; int lat, r;
    for (int n = 0; n < 1000; n++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      ed = av - bv;
      eb = (av < bv);
      r  = int'($signed(av)) - int'($signed(bv));
      eo = (r > 127) || (r < -128);
      do_op(av, bv, d, bo, ov, lat);
      n_checks++;
      if (lat !== 8 || d !== ed || bo !== eb || ov !== eo) begin
        n_fail++;
        $display("FAIL rand%0d a=%h b=%h: lat=%0d diff=%h bo=%b ovf=%b, want 8 %h %b %b",
                 n, av, bv, lat, d, bo, ov, ed, eb, eo);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_single_done: done=%b, want 0", n, done);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
